// File: rtl/norm_pkg.sv
// Shared constants for the sequential normalizer and its barrel-shifter peer.
// Holds the data/count widths, FSM encoding and direction select values.
package norm_pkg;

    localparam int NORM_WIDTH = 8;
    localparam int NORM_CNT_W = 3;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    localparam logic DIR_LEFT  = 1'b1;
    localparam logic DIR_RIGHT = 1'b0;

    typedef enum logic [1:0] {
        S_IDLE  = ST_IDLE,
        S_SHIFT = ST_SHIFT,
        S_DONE  = ST_DONE
    } norm_state_t;

endpackage

// File: rtl/norm_step.sv
// One-bit zero-fill shift in the selected direction plus target-bit detect.
// Purely combinational; the normalizer FSM applies it once per clock.
module norm_step
    import norm_pkg::*;
#(
    parameter int WIDTH = NORM_WIDTH
) (
    input  logic [WIDTH-1:0] word,
    input  logic             lr,
    output logic [WIDTH-1:0] shifted,
    output logic             hit
);

    assign shifted = (lr == DIR_LEFT) ? {word[WIDTH-2:0], 1'b0}
                                      : {1'b0, word[WIDTH-1:1]};

    assign hit = (lr == DIR_LEFT) ? word[WIDTH-1] : word[0];

endmodule

// File: rtl/seq_normalizer_8bit.sv
// Iterative normalizer: shifts one bit per clock until the target bit is set.
// Optional macro NORM_FAST_ZERO_EN finishes an all-zero word straight from IDLE.
module seq_normalizer_8bit
    import norm_pkg::*;
#(
    parameter int WIDTH = NORM_WIDTH,
    parameter int CNT_W = NORM_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] din,
    input  logic             Lr,
    output logic [WIDTH-1:0] dout,
    output logic [CNT_W-1:0] n,
    output logic             zero,
    output logic             busy,
    output logic             done
);

    norm_state_t      state, state_d;
    logic [WIDTH-1:0] work, work_d;
    logic             dir, dir_d;
    logic [CNT_W-1:0] cnt, cnt_d;
    logic [WIDTH-1:0] dout_d;
    logic [CNT_W-1:0] n_d;
    logic             zero_d;
    logic [WIDTH-1:0] work_sh;
    logic             work_hit;

    norm_step #(.WIDTH(WIDTH)) u_step (
        .word    (work),
        .lr      (dir),
        .shifted (work_sh),
        .hit     (work_hit)
    );

    always_comb begin
        state_d = state;
        work_d  = work;
        dir_d   = dir;
        cnt_d   = cnt;
        dout_d  = dout;
        n_d     = n;
        zero_d  = zero;
        unique case (state)
            S_IDLE: begin
                if (start) begin
                    work_d  = din;
                    dir_d   = Lr;
                    cnt_d   = '0;
                    state_d = S_SHIFT;
`ifdef NORM_FAST_ZERO_EN
                    if (din == '0) begin
                        state_d = S_DONE;
                        dout_d  = '0;
                        n_d     = '0;
                        zero_d  = 1'b1;
                    end
`endif
                end
            end
            S_SHIFT: begin
                if (work == '0) begin
                    dout_d  = '0;
                    n_d     = '0;
                    zero_d  = 1'b1;
                    state_d = S_DONE;
                end else if (work_hit) begin
                    dout_d  = work;
                    n_d     = cnt;
                    zero_d  = 1'b0;
                    state_d = S_DONE;
                end else begin
                    // nonzero word hits its target within WIDTH-1 steps
                    work_d = work_sh;
                    cnt_d  = cnt + CNT_W'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            work  <= '0;
            dir   <= DIR_RIGHT;
            cnt   <= '0;
            dout  <= '0;
            n     <= '0;
            zero  <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_d;
            work  <= work_d;
            dir   <= dir_d;
            cnt   <= cnt_d;
            dout  <= dout_d;
            n     <= n_d;
            zero  <= zero_d;
            busy  <= (state_d == S_SHIFT);
            done  <= (state_d == S_DONE);
        end
    end

endmodule

// File: tb/tb_seq_normalizer_8bit.sv
// Scoreboard bench for seq_normalizer_8bit with a count-the-zeros reference.
// Honours NORM_FAST_ZERO_EN when computing zero-input latency.
module tb_seq_normalizer_8bit;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] din;
    logic       Lr;
    logic [7:0] dout;
    logic [2:0] n;
    logic       zero;
    logic       busy;
    logic       done;

    typedef struct {
        logic [7:0] src;
        logic       dir;
        logic [7:0] d;
        logic [2:0] k;
        logic       z;
        int         cyc;
    } exp_t;

    exp_t       q[$];
    int         checks = 0;
    int         failures = 0;
    int         cyc = 0;
    logic [7:0] held_d = 8'h00;
    logic [2:0] held_n = 3'd0;
    logic       held_z = 1'b0;
    logic       prev_done = 1'b0;

    seq_normalizer_8bit dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .din   (din),
        .Lr    (Lr),
        .dout  (dout),
        .n     (n),
        .zero  (zero),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)",
                     name, act, exp, $time);
        end
    endtask

    // Reference: count zeros ahead of the target end, then shift by that.
    function automatic exp_t model(input logic [7:0] d, input logic l,
                                   input int now);
        exp_t e;
        int   k;
        e.src = d;
        e.dir = l;
        k = 0;
        if (d == 8'h00) begin
            e.d = 8'h00;
            e.k = 3'd0;
            e.z = 1'b1;
`ifdef NORM_FAST_ZERO_EN
            e.cyc = now + 1;
`else
            e.cyc = now + 2;
`endif
        end else begin
            if (l) begin
                while (d[7-k] == 1'b0) k++;
                e.d = d << k;
            end else begin
                while (d[k] == 1'b0) k++;
                e.d = d >> k;
            end
            e.k = 3'(k);
            e.z = 1'b0;
            e.cyc = now + k + 2;
        end
        return e;
    endfunction

    // Monitor: compares every done pulse against the scoreboard head.
    always @(negedge clk) begin
        exp_t e;
        if (done) begin
            chk("done_width", {31'd0, prev_done}, 32'd0);
            if (q.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                e = q.pop_front();
                chk("dout", {24'd0, dout}, {24'd0, e.d});
                chk("n", {29'd0, n}, {29'd0, e.k});
                chk("zero", {31'd0, zero}, {31'd0, e.z});
                chk("latency", cyc, e.cyc);
                if (!e.z) begin
                    if (e.dir)
                        chk("restore", {24'd0, dout >> n}, {24'd0, e.src});
                    else
                        chk("restore", {24'd0, dout << n}, {24'd0, e.src});
                end
                held_d = e.d;
                held_n = e.k;
                held_z = e.z;
            end
        end else if (busy) begin
            chk("hold", {20'd0, dout, 1'b0, n, 3'd0, zero},
                {20'd0, held_d, 1'b0, held_n, 3'd0, held_z});
        end
        prev_done = done;
    end

    // Called right after a negedge; start is held for one cycle.
    task automatic issue(input logic [7:0] d, input logic l, input bit push);
        start = 1'b1;
        din   = d;
        Lr    = l;
        if (push) q.push_back(model(d, l, cyc));
        @(negedge clk);
        start = 1'b0;
        din   = 8'($urandom);
        Lr    = 1'($urandom);
    endtask

    task automatic wait_empty();
        int t;
        t = 0;
        while (q.size() != 0 && t < 40) begin
            @(negedge clk);
            t++;
        end
        if (q.size() != 0) begin
            chk("timeout", 32'd1, 32'd0);
            q.delete();
        end
        @(negedge clk);
    endtask

    task automatic check_cleared(input string tag);
        chk({tag, "_dout"}, {24'd0, dout}, 32'd0);
        chk({tag, "_n"}, {29'd0, n}, 32'd0);
        chk({tag, "_zero"}, {31'd0, zero}, 32'd0);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_done"}, {31'd0, done}, 32'd0);
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        din   = 8'h00;
        Lr    = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check_cleared("reset");

        issue(8'b0001_0111, 1'b1, 1'b1);
        wait_empty();
        issue(8'b1011_0111, 1'b0, 1'b1);
        wait_empty();
        issue(8'b1011_0111, 1'b1, 1'b1);
        wait_empty();
        issue(8'b0010_1000, 1'b0, 1'b1);
        wait_empty();
        issue(8'h01, 1'b1, 1'b1);
        wait_empty();
        issue(8'h00, 1'b1, 1'b1);
        wait_empty();
        issue(8'h00, 1'b0, 1'b1);
        wait_empty();
        issue(8'h80, 1'b0, 1'b1);
        wait_empty();

        // start during SHIFT must be ignored
        issue(8'h01, 1'b1, 1'b1);
        @(negedge clk);
        chk("busy_mid", {31'd0, busy}, 32'd1);
        issue(8'hFF, 1'b0, 1'b0);
        wait_empty();

        // reset mid-SHIFT aborts without a done pulse
        issue(8'h01, 1'b1, 1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        held_d = 8'h00;
        held_n = 3'd0;
        held_z = 1'b0;
        check_cleared("abort");
        repeat (12) @(negedge clk);
        issue(8'b0000_0110, 1'b0, 1'b1);
        wait_empty();

        for (int i = 0; i < 200; i++) begin
            logic [7:0] d;
            d = ($urandom_range(0, 9) == 0) ? 8'h00 : 8'($urandom);
            issue(d, 1'($urandom), 1'b1);
            if ($urandom_range(0, 3) == 0) begin
                // stray start while busy
                if (busy) begin
                    start = 1'b1;
                    din   = 8'($urandom);
                    @(negedge clk);
                    start = 1'b0;
                end
            end
            wait_empty();
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        repeat (4) @(negedge clk);
        chk("queue_drained", q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
